// File: rtl/sym_classifier_if.sv
// Byte stream in, classified byte plus class flags and string framing status out.
// master = byte source / consumer side, slave = the classifier.
interface sym_classifier_if #(
  parameter int MAX_LEN = 15
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       byte_out;
  logic             valid;
  logic             start_stop;
  logic             small_letter;
  logic             capital_letter;
  logic             number;
  logic             hex_digit;
  logic             punctuation_basic;
  logic             punctuation_finance;
  logic             parentheses;
  logic             curly_braces;
  logic             math_symbol;
  logic             whitespace;
  logic             vowel;
  logic             consonant;
  logic             other;
  logic             error_verify;
  logic [LEN_W-1:0] str_len;

  modport master (
    output rx_data, rx_valid,
    input  byte_out, valid, start_stop, small_letter, capital_letter, number, hex_digit,
           punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol,
           whitespace, vowel, consonant, other, error_verify, str_len
  );

  modport slave (
    input  rx_data, rx_valid,
    output byte_out, valid, start_stop, small_letter, capital_letter, number, hex_digit,
           punctuation_basic, punctuation_finance, parentheses, curly_braces, math_symbol,
           whitespace, vowel, consonant, other, error_verify, str_len
  );
endinterface

// File: rtl/sym_classifier.sv
// Registers each received byte with its character-class flags and frames \0-delimited
// strings, pulsing error_verify on an over-length string or an inter-byte timeout.
module sym_classifier #(
  parameter int MAX_LEN = 15,
  parameter int TIMEOUT = 1000000
) (
  input logic             clk,
  input logic             rst,
  sym_classifier_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {F_IDLE, F_IN_STR} fstate_t;

  fstate_t          state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             valid_reg;
  logic [7:0]       byte_reg;
  logic [13:0]      flags_reg, flags_next;

  logic [7:0] d;
  logic is_ss, is_small, is_cap, is_num, is_hex, is_pb, is_fin;
  logic is_par, is_curly, is_math, is_ws, is_vowel, is_cons, is_other;

  assign d = bus.rx_data;

  always_comb begin
    is_ss    = (d == 8'h00);
    is_small = (d >= 8'h61) && (d <= 8'h7A);
    is_cap   = (d >= 8'h41) && (d <= 8'h5A);
    is_num   = (d >= 8'h30) && (d <= 8'h39);
    is_hex   = is_num || ((d >= 8'h41) && (d <= 8'h46)) || ((d >= 8'h61) && (d <= 8'h66));
    is_pb    = (d == 8'h2E) || (d == 8'h2C) || (d == 8'h3A) || (d == 8'h3B) ||
               (d == 8'h21) || (d == 8'h3F) || (d == 8'h27) || (d == 8'h22);
    is_fin   = (d == 8'h23) || (d == 8'h24) || (d == 8'h25) || (d == 8'h26) || (d == 8'h40);
    is_par   = (d == 8'h28) || (d == 8'h29) || (d == 8'h5B) || (d == 8'h5D);
    is_curly = (d == 8'h7B) || (d == 8'h7D);
    is_math  = (d == 8'h2B) || (d == 8'h2D) || (d == 8'h2A) || (d == 8'h2F) ||
               (d == 8'h5C) || (d == 8'h3D) || (d == 8'h3C) || (d == 8'h3E);
    is_ws    = (d == 8'h20) || (d == 8'h09) || (d == 8'h0A) || (d == 8'h0D);
    // Fold to lower case (set bit 5) so one comparison set covers both vowel cases
    is_vowel = (is_small || is_cap) &&
               (((d | 8'h20) == 8'h61) || ((d | 8'h20) == 8'h65) || ((d | 8'h20) == 8'h69) ||
                ((d | 8'h20) == 8'h6F) || ((d | 8'h20) == 8'h75));
    is_cons  = (is_small || is_cap) && !is_vowel;
    is_other = !(is_ss || is_small || is_cap || is_num || is_pb || is_fin ||
                 is_par || is_curly || is_math || is_ws);
    flags_next = {is_ss, is_small, is_cap, is_num, is_hex, is_pb, is_fin,
                  is_par, is_curly, is_math, is_ws, is_vowel, is_cons, is_other};
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      F_IDLE: begin
        cnt_next = '0;
        if (bus.rx_valid && is_ss) begin
          state_next = F_IN_STR;
          len_next   = '0;
        end
      end
      F_IN_STR: begin
        if (bus.rx_valid) begin
          cnt_next = '0;
          if (is_ss) begin
            state_next = F_IDLE;
          end else if (len_reg == LEN_W'(MAX_LEN)) begin
            state_next = F_IDLE;
            err_next   = 1'b1;
          end else begin
            len_next = len_reg + LEN_W'(1);
          end
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // This idle cycle would bring the count to TIMEOUT: abort the string now
          state_next = F_IDLE;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= F_IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      byte_reg  <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      valid_reg <= bus.rx_valid;
      if (bus.rx_valid) begin
        byte_reg  <= bus.rx_data;
        flags_reg <= flags_next;
      end
    end
  end

  assign bus.byte_out            = byte_reg;
  assign bus.valid               = valid_reg;
  assign bus.error_verify        = err_reg;
  assign bus.str_len             = len_reg;
  assign bus.start_stop          = flags_reg[13];
  assign bus.small_letter        = flags_reg[12];
  assign bus.capital_letter      = flags_reg[11];
  assign bus.number              = flags_reg[10];
  assign bus.hex_digit           = flags_reg[9];
  assign bus.punctuation_basic   = flags_reg[8];
  assign bus.punctuation_finance = flags_reg[7];
  assign bus.parentheses         = flags_reg[6];
  assign bus.curly_braces        = flags_reg[5];
  assign bus.math_symbol         = flags_reg[4];
  assign bus.whitespace          = flags_reg[3];
  assign bus.vowel               = flags_reg[2];
  assign bus.consonant           = flags_reg[1];
  assign bus.other               = flags_reg[0];
endmodule

// File: tb/tb_sym_classifier.sv
// Directed bench: two classifiers (MAX_LEN 15 and 3, TIMEOUT 20) share one byte stream.
module tb_sym_classifier;
  localparam logic [13:0] SS = 14'h2000, SM = 14'h1000, CA = 14'h0800, NU = 14'h0400;
  localparam logic [13:0] HX = 14'h0200, PB = 14'h0100, FI = 14'h0080, PA = 14'h0040;
  localparam logic [13:0] CU = 14'h0020, MA = 14'h0010, WS = 14'h0008, VO = 14'h0004;
  localparam logic [13:0] CO = 14'h0002, OT = 14'h0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  int         n_checks = 0;
  int         n_err = 0;

  sym_classifier_if #(.MAX_LEN(15)) bus_a ();
  sym_classifier_if #(.MAX_LEN(3))  bus_b ();

  assign bus_a.rx_data  = rx_data;
  assign bus_a.rx_valid = rx_valid;
  assign bus_b.rx_data  = rx_data;
  assign bus_b.rx_valid = rx_valid;

  sym_classifier #(.MAX_LEN(15), .TIMEOUT(20)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sym_classifier #(.MAX_LEN(3),  .TIMEOUT(20)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  logic [13:0] flags_a;
  assign flags_a = {bus_a.start_stop, bus_a.small_letter, bus_a.capital_letter, bus_a.number,
                    bus_a.hex_digit, bus_a.punctuation_basic, bus_a.punctuation_finance,
                    bus_a.parentheses, bus_a.curly_braces, bus_a.math_symbol,
                    bus_a.whitespace, bus_a.vowel, bus_a.consonant, bus_a.other};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock cycle: present inputs at a falling edge, observe results at the next one
  task automatic step(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0]  t1_byte [7];
  logic [13:0] t1_flag [7];
  logic [7:0]  t2_byte [10];
  logic [13:0] t2_flag [10];
  int          errs;

  initial begin
    t1_byte = '{8'h00, 8'h28, 8'h2B, 8'h31, 8'h32, 8'h29, 8'h00};
    t1_flag = '{SS, PA, MA, NU | HX, NU | HX, PA, SS};
    t2_byte = '{8'h45, 8'h7E, 8'h20, 8'h24, 8'h7B, 8'h5C, 8'h7A, 8'h62, 8'h3F, 8'h55};
    t2_flag = '{CA | HX | VO, OT, WS, FI, CU, MA, SM | CO, SM | HX | CO, PB, CA | VO};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset flags", 32'(flags_a), 32'h0);
    check("reset byte_out", 32'(bus_a.byte_out), 32'h0);
    check("reset valid", 32'(bus_a.valid), 32'h0);
    check("reset error", 32'(bus_a.error_verify), 32'h0);
    check("reset str_len", 32'(bus_a.str_len), 32'h0);
    rst = 1'b0;

    // "\0(+12)\0" back to back
    for (int i = 0; i < 7; i++) begin
      step(1'b1, t1_byte[i]);
      check($sformatf("t1 valid[%0d]", i), 32'(bus_a.valid), 32'h1);
      check($sformatf("t1 byte[%0d]", i), 32'(bus_a.byte_out), 32'(t1_byte[i]));
      check($sformatf("t1 flags[%0d]", i), 32'(flags_a), 32'(t1_flag[i]));
    end
    check("t1 str_len", 32'(bus_a.str_len), 32'd5);
    step(1'b0, 8'h55);
    check("t1 valid drop", 32'(bus_a.valid), 32'h0);
    check("t1 flags hold", 32'(flags_a), 32'(SS));

    // Class table, sent from idle
    for (int i = 0; i < 10; i++) begin
      step(1'b1, t2_byte[i]);
      check($sformatf("t2 flags %0h", t2_byte[i]), 32'(flags_a), 32'(t2_flag[i]));
    end

    // Timeout after 20 idle cycles
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h61);
    check("t3 str_len", 32'(bus_a.str_len), 32'd1);
    errs = 0;
    for (int i = 1; i <= 19; i++) begin
      step(1'b0, 8'h00);
      errs += int'(bus_a.error_verify);
    end
    check("t3 no early error", 32'(errs), 32'd0);
    step(1'b0, 8'h00);
    check("t3 error at 20", 32'(bus_a.error_verify), 32'h1);
    step(1'b0, 8'h00);
    check("t3 error pulse", 32'(bus_a.error_verify), 32'h0);
    step(1'b1, 8'h78);
    check("t3 idle no count", 32'(bus_a.str_len), 32'd1);

    // Byte on the 20th idle cycle wins over timeout
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h61);
    for (int i = 1; i <= 19; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h62);
    check("t5 no error", 32'(bus_a.error_verify), 32'h0);
    check("t5 str_len", 32'(bus_a.str_len), 32'd2);
    errs = 0;
    for (int i = 1; i <= 19; i++) begin
      step(1'b0, 8'h00);
      errs += int'(bus_a.error_verify);
    end
    check("t5 restarted count", 32'(errs), 32'd0);
    step(1'b0, 8'h00);
    check("t5 later timeout", 32'(bus_a.error_verify), 32'h1);

    // Over-length string on the MAX_LEN=3 instance
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h61);
    step(1'b1, 8'h62);
    step(1'b1, 8'h63);
    check("t4 str_len max", 32'(bus_b.str_len), 32'd3);
    check("t4 no error yet", 32'(bus_b.error_verify), 32'h0);
    step(1'b1, 8'h64);
    check("t4 error", 32'(bus_b.error_verify), 32'h1);
    check("t4 valid", 32'(bus_b.valid), 32'h1);
    check("t4 byte", 32'(bus_b.byte_out), 32'h64);
    step(1'b1, 8'h00);
    check("t4 new str_len", 32'(bus_b.str_len), 32'd0);
    check("t4 error pulse", 32'(bus_b.error_verify), 32'h0);
    step(1'b1, 8'h65);
    check("t4 counting", 32'(bus_b.str_len), 32'd1);

    // Reset mid-string
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h61);
    step(1'b1, 8'h62);
    check("t6 str_len", 32'(bus_a.str_len), 32'd2);
    rst = 1'b1;
    step(1'b0, 8'h00);
    rst = 1'b0;
    check("t6 rst flags", 32'(flags_a), 32'h0);
    check("t6 rst byte", 32'(bus_a.byte_out), 32'h0);
    check("t6 rst valid", 32'(bus_a.valid), 32'h0);
    check("t6 rst str_len", 32'(bus_a.str_len), 32'h0);
    step(1'b1, 8'h63);
    check("t6 c valid", 32'(bus_a.valid), 32'h1);
    check("t6 c flags", 32'(flags_a), 32'(SM | HX | CO));
    check("t6 c not counted", 32'(bus_a.str_len), 32'd0);
    errs = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 8'h00);
      errs += int'(bus_a.error_verify);
    end
    check("t6 no timeout idle", 32'(errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
